// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial transmit controller (SERIAL_TX_PARITY_EN adds PAR state).
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package serial_tx_pkg;

    localparam int PORT_BITS_DEF = 2;
    localparam int CNT_BITS_DEF  = 4;
    localparam int MAX_PORT_BITS = 8;
    localparam int MAX_PORTS     = 1 << MAX_PORT_BITS;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PORT = 3'd1,
        ST_CNT  = 3'd2,
        ST_XMIT = 3'd3,
`ifdef SERIAL_TX_PARITY_EN
        ST_PAR  = 3'd4,
`endif
        ST_DONE = 3'd5
    } tx_state_t;

    function automatic logic [MAX_PORTS-1:0] onehot_port(input logic [MAX_PORT_BITS-1:0] port);
        return {{(MAX_PORTS-1){1'b0}}, 1'b1} << port;
    endfunction

endpackage

// File: rtl/serial_tx_bitcnt.sv
// Loadable down-counter with zero flag, shared by the header and payload phases.
// Latency: load/decrement visible one edge later; zero flag is combinational on the count.
// Backpressure: none; load has priority over decrement.
module serial_tx_bitcnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/serial_tx_controller.sv
// Captures port/count headers after a detect and routes that many SIn bits to one port (SERIAL_TX_PARITY_EN adds even-parity check).
// Latency: payload routed combinationally; first payload bit PORT_BITS+CNT_BITS+1 cycles after detect.
// Backpressure: none; detect is ignored while a frame is in flight.
module serial_tx_controller
    import serial_tx_pkg::*;
#(
    parameter int PORT_BITS = PORT_BITS_DEF,
    parameter int CNT_BITS  = CNT_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      SIn,
    input  logic                      detected,
    output logic [(2**PORT_BITS)-1:0] dout,
    output logic [(2**PORT_BITS)-1:0] dout_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int NUM_PORTS = 2**PORT_BITS;
    localparam int CW        = (PORT_BITS > CNT_BITS) ? PORT_BITS : CNT_BITS;

`ifdef SERIAL_TX_PARITY_EN
    localparam tx_state_t ST_AFTER_PAYLOAD = ST_PAR;
`else
    localparam tx_state_t ST_AFTER_PAYLOAD = ST_DONE;
`endif

    tx_state_t              state_q, state_d;
    logic [PORT_BITS-1:0]   port_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [CNT_BITS-1:0]    cnt_full;
    logic                   cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]          cnt_load_val;
    logic [NUM_PORTS-1:0]   port_oh;
    logic                   xmit;

    // Count field including the bit being sampled this cycle.
    assign cnt_full = CNT_BITS'({cnt_q, SIn});

    serial_tx_bitcnt #(.W(CW)) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (detected) begin
                    state_d      = ST_PORT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(PORT_BITS - 1);
                end
            end
            ST_PORT: begin
                if (cnt_zero) begin
                    state_d      = ST_CNT;
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(CNT_BITS - 1);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_CNT: begin
                if (cnt_zero) begin
                    if (cnt_full == '0) begin
                        state_d = ST_AFTER_PAYLOAD;
                    end else begin
                        state_d      = ST_XMIT;
                        cnt_load     = 1'b1;
                        cnt_load_val = CW'(cnt_full) - CW'(1);
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_XMIT: begin
                if (cnt_zero) begin
                    state_d = ST_AFTER_PAYLOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PAR:  state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == ST_PORT) begin
                port_q <= PORT_BITS'({port_q, SIn});
            end
            if (state_q == ST_CNT) begin
                cnt_q <= cnt_full;
            end
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    logic par_acc, err_q;

    // Accumulator is cleared when leaving CNT so zero-length frames check the parity bit alone.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_acc <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == ST_CNT && cnt_zero) begin
                par_acc <= 1'b0;
            end else if (state_q == ST_XMIT) begin
                par_acc <= par_acc ^ SIn;
            end
            if (state_q == ST_PAR) begin
                err_q <= par_acc ^ SIn;
            end
        end
    end

    assign err = (state_q == ST_DONE) && err_q;
`else
    assign err = 1'b0;
`endif

    assign port_oh    = NUM_PORTS'(onehot_port(MAX_PORT_BITS'(port_q)));
    assign xmit       = (state_q == ST_XMIT);
    assign dout_valid = xmit ? port_oh : '0;
    assign dout       = xmit ? (port_oh & {NUM_PORTS{SIn}}) : '0;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_tx_controller.sv
// Randomized scoreboard bench for serial_tx_controller: driver queues expected payload/done/busy, monitor compares.
module tb_serial_tx_controller;

    localparam int PB = 2;
    localparam int CB = 4;
    localparam int NP = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          SIn;
    logic          detected;
    logic [NP-1:0] dout;
    logic [NP-1:0] dout_valid;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    serial_tx_controller #(.PORT_BITS(PB), .CNT_BITS(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .SIn        (SIn),
        .detected   (detected),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        int   port;
        logic b;
    } xbit_t;

    xbit_t exp_x[$];
    logic  exp_done[$];
    int    exp_busy[$];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step(input logic det, input logic s);
        @(posedge clk);
        #2;
        detected = det;
        SIn      = s;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_dout"},       32'(dout),       0);
        chk({tag, "_dout_valid"}, 32'(dout_valid), 0);
        chk({tag, "_busy"},       32'(busy),       0);
        chk({tag, "_done"},       32'(done),       0);
        chk({tag, "_err"},        32'(err),        0);
    endtask

    // Reference: a frame is header + count payload bits (+ parity) + one done cycle.
    task automatic push_expect(input int port, input int cnt, input logic [15:0] pay, input logic pb);
        logic par;
        par = 1'b0;
        exp_busy.push_back(PB + CB + cnt + PAR_EN + 1);
        for (int i = 0; i < cnt; i++) begin
            exp_x.push_back('{port, pay[i]});
            par ^= pay[i];
        end
        exp_done.push_back((PAR_EN != 0) ? (par ^ pb) : 1'b0);
    endtask

    task automatic send_header(input int port, input int cnt);
        logic [PB-1:0] p;
        logic [CB-1:0] c;
        p = PB'(port);
        c = CB'(cnt);
        step(1'b1, 1'($urandom));
        for (int i = PB - 1; i >= 0; i--) step(1'b0, p[i]);
        for (int i = CB - 1; i >= 0; i--) step(1'b0, c[i]);
    endtask

    task automatic frame(input int port, input int cnt, input logic [15:0] pay, input logic pb,
                         input bit det_x, input bit det_d);
        push_expect(port, cnt, pay, pb);
        send_header(port, cnt);
        for (int i = 0; i < cnt; i++) step(det_x && (i == cnt / 2), pay[i]);
        if (PAR_EN != 0) step(1'b0, pb);
        step(det_d, 1'($urandom));
    endtask

    task automatic reset_mid(input int port, input int cnt, input logic [15:0] pay);
        push_expect(port, cnt, pay, 1'b0);
        send_header(port, cnt);
        step(1'b0, pay[0]);
        step(1'b0, pay[1]);
        #1 rst = 1'b0;
        exp_x.delete();
        exp_done.delete();
        exp_busy.delete();
        #1 check_quiet("midreset");
        step(1'b0, 1'($urandom));
        step(1'b0, 1'($urandom));
        #1 rst = 1'b1;
    endtask

    // Monitor: compares every cycle against the scoreboard queues.
    initial begin
        int    run;
        xbit_t e;
        logic [NP-1:0] oh;
        run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                run = 0;
            end else begin
                if (dout_valid != '0) begin
                    if (exp_x.size() == 0) begin
                        chk("unexpected_valid", 32'(exp_x.size()), 1);
                    end else begin
                        e  = exp_x.pop_front();
                        oh = NP'(1) << e.port;
                        chk("dout_valid", 32'(dout_valid), 32'(oh));
                        chk("dout",       32'(dout),       e.b ? 32'(oh) : 32'd0);
                    end
                end else begin
                    chk("dout_idle", 32'(dout), 0);
                end
                if (done) begin
                    if (exp_done.size() == 0) chk("unexpected_done", 32'(exp_done.size()), 1);
                    else                      chk("err_at_done", 32'(err), 32'(exp_done.pop_front()));
                end else begin
                    chk("err_idle", 32'(err), 0);
                end
                if (busy) begin
                    run++;
                end else if (run > 0) begin
                    if (exp_busy.size() == 0) chk("unexpected_busy", 32'(exp_busy.size()), 1);
                    else                      chk("busy_len", 32'(run), 32'(exp_busy.pop_front()));
                    run = 0;
                end
            end
        end
    end

    initial begin
        rst      = 1'b0;
        SIn      = 1'b0;
        detected = 1'b0;
        #3 check_quiet("reset");
        #20 rst = 1'b1;
        idle(2);

        frame(2, 3, 16'b101, 1'b0, 1'b0, 1'b0);
        idle(2);
        frame(1, 0, 16'h0, 1'b0, 1'b0, 1'b0);
        idle(1);
        frame(3, 15, 16'h5555, 1'b0, 1'b0, 1'b0);
        idle(1);
        frame(0, 5, 16'($urandom), 1'($urandom), 1'b1, 1'b1);
        idle(6);
        reset_mid(2, 4, 16'b1011);
        idle(2);
        frame(1, 2, 16'b10, 1'b1, 1'b0, 1'b0);
        idle(2);
        frame(1, 3, 16'b011, 1'b1, 1'b0, 1'b0);
        idle(1);
        frame(1, 3, 16'b011, 1'b0, 1'b0, 1'b0);
        idle(1);

        for (int k = 0; k < 40; k++) begin
            frame(int'($urandom_range(0, NP - 1)), int'($urandom_range(0, 15)), 16'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            idle(int'($urandom_range(0, 2)));
        end

        idle(4);
        chk("leftover_payload", 32'(exp_x.size()),    0);
        chk("leftover_done",    32'(exp_done.size()), 0);
        chk("leftover_busy",    32'(exp_busy.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/serial_tx_controller.md
# serial_tx_controller

Sequencing controller for the serial transmitter. It sits behind the sequence detector: on a `detected` pulse it captures a port-number header and a bit-count header from `SIn`. It then routes exactly that many payload bits from `SIn` to the selected output port and returns to idle. It is the single owner of the serial line between detections, so the detector output is ignored while a frame is in flight.

## Interface
- `PORT_BITS`, default 2: header port-field width; number of output ports `NUM_PORTS = 2**PORT_BITS`.
- `CNT_BITS`, default 4: header count-field width; payload length range 0 to `2**CNT_BITS-1`.

Ports:
- `clk`  in  1: single clock, all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `SIn`  in  1: serial input line, shared with the sequence detector.
- `detected`  in  1: one-cycle pulse from the sequence detector; the next `SIn` sample is the first header bit.
- `dout`  out  `NUM_PORTS`: routed payload; `dout[port] = SIn` during transmit, all other bits 0.
- `dout_valid`  out  `NUM_PORTS`: one-hot of the selected port during transmit, else 0.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse at frame end.
- `err`  out  1: parity error flag, asserted together with `done`.

## Operation
- States: IDLE, PORT, CNT, XMIT, (PAR), DONE.
- **IDLE:** with `detected`=1 at an edge -> PORT. The bit counter loads `PORT_BITS-1`.
- **PORT:** shift `SIn` into `port_q`, MSB first, for `PORT_BITS` edges. When the counter reaches 0 -> CNT, and the counter loads `CNT_BITS-1`.
- **CNT:** shift `SIn` into `cnt_q`, MSB first, for `CNT_BITS` edges. When the counter reaches 0:
  - if the assembled count is 0 -> DONE (or PAR if enabled);
  - otherwise -> XMIT, and the counter loads count-1.
- **XMIT:** one payload bit per cycle, for count cycles. At counter 0 -> PAR if enabled, else DONE.
- **DONE:** `done`=1 for one cycle, then -> IDLE unconditionally.
- `detected` is ignored outside IDLE, including in DONE.
- `dout` and `dout_valid` are combinational decodes of the registered state, `port_q` and live `SIn`, with no added latency.
- Counter arithmetic is unsigned; its width is `max(PORT_BITS, CNT_BITS)`; no wrap occurs because each load is at most the field maximum.
- Reset values: state IDLE; `port_q`, `cnt_q`, counter and parity accumulator all 0; `dout`=0, `dout_valid`=0, `busy`=0, `done`=0, `err`=0.
- Reset asserted mid-frame aborts the frame immediately; outputs go to their reset values asynchronously, and no `done` is produced.

## Timing
- `detected` high at edge t: header bits are sampled at edges t+1 .. t+`PORT_BITS`+`CNT_BITS`.
- First payload bit is presented at cycle t+`PORT_BITS`+`CNT_BITS`+1.
- `done` occurs in the cycle immediately after the last payload bit (after the parity bit if enabled).
- Minimum frame with count 0 and no parity: `busy` for `PORT_BITS`+`CNT_BITS`+1 cycles.
- `busy` rises one edge after `detected` and falls when leaving DONE.

## Configuration
- Macro: `SERIAL_TX_PARITY_EN`.
- **Defined:**
  - A PAR state follows XMIT (or CNT when count is 0).
  - The parity accumulator is cleared on entry to XMIT and XORs each payload bit.
  - PAR samples one even-parity bit from `SIn`; `dout_valid` is 0 in PAR.
  - `err`=1 in the DONE cycle if the accumulator XOR the parity bit is 1.
- **Undefined:** no PAR state, no accumulator, and `err` is tied to 0.

## Structure
- Package `serial_tx_pkg` holds:
  - the state enum `tx_state_t`;
  - default `PORT_BITS`/`CNT_BITS` localparams;
  - the function `onehot_port()`.
- One sub-module, `serial_tx_bitcnt`: a loadable down-counter with a zero flag, shared by the PORT, CNT and XMIT phases.

## Test plan
- **Basic frame.** `detected` pulse, then `SIn` 1,0 (port 2), then 0,0,1,1 (count 3), then 1,0,1 -> for 3 cycles `dout_valid`=4'b0100 and `dout[2]` = 1,0,1; all other `dout` bits 0; `done` pulses one cycle later; `busy` spans 10 cycles.
- **Zero count.** Port 1, count 0000 -> `dout_valid` never asserts; `done` in the cycle after the last count bit.
- **Maximum length.** Port 3, count 1111, alternating payload -> `dout[3]` mirrors `SIn` for exactly 15 cycles, then `done`.
- **Ignored detect.** `detected` pulsed during XMIT and during DONE -> frame unaffected; IDLE is reached and no new frame starts.
- **Reset mid-frame.** `rst` driven low in the 2nd payload cycle -> all outputs 0 at once, no `done`; a new `detected` after release starts a clean frame.
- **Parity (with `SERIAL_TX_PARITY_EN`).** Payload 1,1,0 with parity bit 1 -> `err`=1 together with `done`. Parity bit 0 -> `err`=0.
